// File: rtl/filter_3x3.sv
// ---------------------------------------------------------------------------
// filter_3x3
// Single-window 3x3 convolution multiply-accumulate block. Each enabled cycle
// it takes one packed 3x3 image window and one packed 3x3 kernel. It forms
// the nine element-wise signed products in stage 1 and sums them in stage 2.
// The result appears on out two enabled edges after the inputs were sampled.
//
// Ports:
//   clk          in   system clock, all state updates on the rising edge
//   rst          in   synchronous active-high reset, clears all pipeline state
//   ena          in   pipeline advance enable, low holds every register
//   inMatrix     in   packed 3x3 image window (element 0 in the MS slice)
//   filterMatrix in   packed 3x3 kernel, same packing as inMatrix
//   out          out  registered sum of the nine products, wrap-around
// ---------------------------------------------------------------------------

`ifndef IMG_DATA_WIDTH
`define IMG_DATA_WIDTH 16
`endif

`ifndef IMG_DATA_MATRIX_WIDTH
`define IMG_DATA_MATRIX_WIDTH (9*`IMG_DATA_WIDTH)
`endif

module filter_3x3 #(
  parameter int DATA_WIDTH   = `IMG_DATA_WIDTH,
  parameter int MATRIX_WIDTH = `IMG_DATA_MATRIX_WIDTH
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      ena,
  input  logic [MATRIX_WIDTH-1:0]   inMatrix,
  input  logic [MATRIX_WIDTH-1:0]   filterMatrix,
  output logic [2*DATA_WIDTH-1:0]   out
);

  localparam int PROD_WIDTH = 2 * DATA_WIDTH;
  // Four guard bits are enough headroom for nine full-precision products.
  localparam int SUM_WIDTH  = PROD_WIDTH + 4;

  logic signed [DATA_WIDTH-1:0] in_elem   [9];
  logic signed [DATA_WIDTH-1:0] flt_elem  [9];

  logic signed [PROD_WIDTH-1:0] prod_d    [9];
  logic signed [PROD_WIDTH-1:0] prod_q    [9];

  // Adder tree levels: 9 -> 5 -> 3 -> 2 -> 1.
  logic signed [SUM_WIDTH-1:0]  lvl1      [5];
  logic signed [SUM_WIDTH-1:0]  lvl2      [3];
  logic signed [SUM_WIDTH-1:0]  lvl3      [2];
  logic signed [SUM_WIDTH-1:0]  sum_full;

  logic [PROD_WIDTH-1:0]        out_d;
  logic [PROD_WIDTH-1:0]        out_q;

  // Element k is row-major with element 0 in the most significant slice.
  for (genvar k = 0; k < 9; k++) begin : g_unpack
    assign in_elem[k]  = inMatrix[(8-k)*DATA_WIDTH +: DATA_WIDTH];
    assign flt_elem[k] = filterMatrix[(8-k)*DATA_WIDTH +: DATA_WIDTH];
  end

  // Stage 1 next state: full-precision signed products. Both operands are
  // sign-extended to the product width so the multiply is exact.
  always_comb begin
    for (int k = 0; k < 9; k++) begin
      prod_d[k] = prod_q[k];
    end
    if (ena) begin
      for (int k = 0; k < 9; k++) begin
        prod_d[k] = PROD_WIDTH'(in_elem[k]) * PROD_WIDTH'(flt_elem[k]);
      end
    end
  end

  // Stage 2 next state: balanced adder tree over the registered products.
  // The sum is computed wide, then truncated to the low product-width bits.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      lvl1[i] = SUM_WIDTH'(prod_q[2*i]) + SUM_WIDTH'(prod_q[2*i+1]);
    end
    lvl1[4] = SUM_WIDTH'(prod_q[8]);

    lvl2[0] = lvl1[0] + lvl1[1];
    lvl2[1] = lvl1[2] + lvl1[3];
    lvl2[2] = lvl1[4];

    lvl3[0] = lvl2[0] + lvl2[1];
    lvl3[1] = lvl2[2];

    sum_full = lvl3[0] + lvl3[1];

    out_d = out_q;
    if (ena) begin
      out_d = sum_full[PROD_WIDTH-1:0];
    end
  end

  // Pipeline registers. Reset wins over enable and clears everything in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < 9; k++) begin
        prod_q[k] <= '0;
      end
      out_q <= '0;
    end else begin
      for (int k = 0; k < 9; k++) begin
        prod_q[k] <= prod_d[k];
      end
      out_q <= out_d;
    end
  end

  assign out = out_q;

endmodule

// File: tb/tb_filter_3x3.sv
// ---------------------------------------------------------------------------
// tb_filter_3x3
// Directed self-checking bench for filter_3x3 at DATA_WIDTH = 16. Each task
// drives one scenario and compares out against hand-computed values.
// ---------------------------------------------------------------------------

module tb_filter_3x3;

  localparam int DW = 16;
  localparam int MW = 9 * DW;

  logic          clk;
  logic          rst;
  logic          ena;
  logic [MW-1:0] in_matrix;
  logic [MW-1:0] filter_matrix;
  logic [2*DW-1:0] out;

  int checks;
  int failures;

  filter_3x3 #(
    .DATA_WIDTH  (DW),
    .MATRIX_WIDTH(MW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .ena         (ena),
    .inMatrix    (in_matrix),
    .filterMatrix(filter_matrix),
    .out         (out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Packs nine elements, element 0 ending up in the most significant slice.
  function automatic logic [MW-1:0] pack9(
    input logic [DW-1:0] e0, input logic [DW-1:0] e1, input logic [DW-1:0] e2,
    input logic [DW-1:0] e3, input logic [DW-1:0] e4, input logic [DW-1:0] e5,
    input logic [DW-1:0] e6, input logic [DW-1:0] e7, input logic [DW-1:0] e8);
    return {e0, e1, e2, e3, e4, e5, e6, e7, e8};
  endfunction

  // Advance one rising edge, then settle so outputs are sampled off the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_a();
    in_matrix     = pack9(16'd1, 16'd2, 16'd1, 16'd2, 16'd1, 16'd1, 16'd1, 16'd1, 16'd2);
    filter_matrix = pack9(16'd1, 16'd1, 16'd1, 16'd1, 16'd1, 16'd1, 16'd1, 16'd1, 16'd1);
  endtask

  task automatic drive_b();
    in_matrix     = pack9(16'd2, 16'd2, 16'd1, 16'd1, 16'd1, 16'd1, 16'd1, 16'd2, 16'd2);
    filter_matrix = pack9(16'd2, 16'd1, 16'd1, 16'd2, 16'd2, 16'd2, 16'd1, 16'd1, 16'd2);
  endtask

  task automatic drive_sevens();
    in_matrix     = pack9(16'd7, 16'd7, 16'd7, 16'd7, 16'd7, 16'd7, 16'd7, 16'd7, 16'd7);
    filter_matrix = pack9(16'd7, 16'd7, 16'd7, 16'd7, 16'd7, 16'd7, 16'd7, 16'd7, 16'd7);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    ena = 1'b1;
    for (int i = 0; i < 2; i++) begin
      for (int k = 0; k < 9; k++) begin
        in_matrix[k*DW +: DW]     = DW'($urandom);
        filter_matrix[k*DW +: DW] = DW'($urandom);
      end
      step();
      checks++;
      if (out !== 32'h0) begin
        failures++;
        $display("[TB] FAIL reset_hold_%0d: got 0x%08h expected 0x%08h", i, out, 32'h0);
      end
    end
    rst = 1'b0;
    drive_a();
    step();
    checks++;
    if (out !== 32'h0) begin
      failures++;
      $display("[TB] FAIL reset_release: got 0x%08h expected 0x%08h", out, 32'h0);
    end
  endtask

  task automatic test_ones_kernel();
    drive_a();
    step();
    step();
    checks++;
    if (out !== 32'h0000_000C) begin
      failures++;
      $display("[TB] FAIL ones_kernel: got 0x%08h expected 0x%08h", out, 32'h0000_000C);
    end
  endtask

  task automatic test_back_to_back();
    drive_a();
    step();
    drive_b();
    step();
    checks++;
    if (out !== 32'd12) begin
      failures++;
      $display("[TB] FAIL b2b_first: got 0x%08h expected 0x%08h", out, 32'd12);
    end
    step();
    checks++;
    if (out !== 32'd20) begin
      failures++;
      $display("[TB] FAIL b2b_second: got 0x%08h expected 0x%08h", out, 32'd20);
    end
  endtask

  task automatic test_stall();
    ena = 1'b1;
    drive_a();
    step();
    drive_b();
    step();
    checks++;
    if (out !== 32'd12) begin
      failures++;
      $display("[TB] FAIL stall_pre: got 0x%08h expected 0x%08h", out, 32'd12);
    end
    // Window B is now in stage 1; stall with different data on the inputs.
    ena = 1'b0;
    drive_sevens();
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (out !== 32'd12) begin
        failures++;
        $display("[TB] FAIL stall_hold_%0d: got 0x%08h expected 0x%08h", i, out, 32'd12);
      end
    end
    ena = 1'b1;
    step();
    checks++;
    if (out !== 32'd20) begin
      failures++;
      $display("[TB] FAIL stall_resume: got 0x%08h expected 0x%08h", out, 32'd20);
    end
    // Sevens were sampled only at the resume edge: 9 * 49 = 441.
    step();
    checks++;
    if (out !== 32'd441) begin
      failures++;
      $display("[TB] FAIL stall_next: got 0x%08h expected 0x%08h", out, 32'd441);
    end
  endtask

  task automatic test_signed();
    ena = 1'b1;
    in_matrix     = {9{16'hFFFF}};
    filter_matrix = {9{16'h0002}};
    step();
    step();
    checks++;
    if (out !== 32'hFFFF_FFEE) begin
      failures++;
      $display("[TB] FAIL signed_neg: got 0x%08h expected 0x%08h", out, 32'hFFFF_FFEE);
    end
    in_matrix     = {9{16'h7FFF}};
    filter_matrix = {9{16'h7FFF}};
    step();
    step();
    checks++;
    if (out !== 32'h3FF7_0009) begin
      failures++;
      $display("[TB] FAIL signed_wrap: got 0x%08h expected 0x%08h", out, 32'h3FF7_0009);
    end
  endtask

  task automatic test_reset_mid();
    ena = 1'b1;
    drive_a();
    step();
    drive_b();
    step();
    checks++;
    if (out !== 32'd12) begin
      failures++;
      $display("[TB] FAIL midrst_pre: got 0x%08h expected 0x%08h", out, 32'd12);
    end
    // Window B sits in stage 1 when reset hits.
    rst = 1'b1;
    drive_a();
    step();
    checks++;
    if (out !== 32'h0) begin
      failures++;
      $display("[TB] FAIL midrst_clear: got 0x%08h expected 0x%08h", out, 32'h0);
    end
    rst = 1'b0;
    step();
    checks++;
    if (out !== 32'h0) begin
      failures++;
      $display("[TB] FAIL midrst_first: got 0x%08h expected 0x%08h", out, 32'h0);
    end
    step();
    checks++;
    if (out !== 32'd12) begin
      failures++;
      $display("[TB] FAIL midrst_second: got 0x%08h expected 0x%08h", out, 32'd12);
    end
  endtask

  initial begin
    checks        = 0;
    failures      = 0;
    rst           = 1'b1;
    ena           = 1'b0;
    in_matrix     = '0;
    filter_matrix = '0;

    test_reset();
    test_ones_kernel();
    test_back_to_back();
    test_stall();
    test_signed();
    test_reset_mid();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
